// File: rtl/seq_chunk_adder_if.sv
// Handshake and operand/result bundle for the chunked add/subtract unit.
interface seq_chunk_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, c_in, sub,
        input  sum, c_out, ovf, busy, done
    );

    modport slave (
        input  start, a, b, c_in, sub,
        output sum, c_out, ovf, busy, done
    );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract: adds CHUNK bits per clock, LSB chunk first,
// with the carry registered between chunks and a one-cycle done pulse.
module seq_chunk_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_chunk_adder_if.slave  bus
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned CSW    = CHUNK + 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    generate
        if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("seq_chunk_adder: WIDTH must be >= 1 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry;
    logic             a_sign;
    logic             b_sign;
    logic [WIDTH-1:0] part;
    logic [WIDTH-1:0] sum_r;
    logic             c_out_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;

    logic [CHUNK:0]   chunk_c;
    logic [WIDTH-1:0] part_next_c;

    // Operands shift down so the active chunk is always the low CHUNK bits;
    // result chunks enter at the top and shift down into place.
    always_comb begin
        chunk_c     = CSW'(a_r[CHUNK-1:0]) + CSW'(b_r[CHUNK-1:0]) + CSW'(carry);
        part_next_c = (part >> CHUNK) | (WIDTH'(chunk_c[CHUNK-1:0]) << (WIDTH - CHUNK));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            carry   <= 1'b0;
            a_sign  <= 1'b0;
            b_sign  <= 1'b0;
            part    <= '0;
            sum_r   <= '0;
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= RUN;
                        a_r    <= bus.a;
                        b_r    <= bus.sub ? ~bus.b : bus.b;
                        carry  <= bus.sub ? 1'b1 : bus.c_in;
                        a_sign <= bus.a[WIDTH-1];
                        b_sign <= bus.sub ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
                        cnt    <= '0;
                        part   <= '0;
                        busy_r <= 1'b1;
                    end
                end
                RUN: begin
                    a_r   <= a_r >> CHUNK;
                    b_r   <= b_r >> CHUNK;
                    carry <= chunk_c[CHUNK];
                    part  <= part_next_c;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state   <= IDLE;
                        sum_r   <= part_next_c;
                        c_out_r <= chunk_c[CHUNK];
                        ovf_r   <= (a_sign == b_sign) && (part_next_c[WIDTH-1] != a_sign);
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sum   = sum_r;
    assign bus.c_out = c_out_r;
    assign bus.ovf   = ovf_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
endmodule
